// File: rtl/nyq_interp.sv
// Transmit-side Nyquist interpolator: upsample by 8 through a
// 32-tap polyphase FIR (8 phases x 4 taps), coefficients in param memory.
module nyq_interp #(
    parameter int ADDR_WIDTH = 6,
    parameter int MEM_WIDTH  = 24,
    parameter int IN_WIDTH   = 24,
    parameter int OUT_WIDTH  = 24
) (
    input  logic                        Clk_CI,
    input  logic                        Rst_RBI,
    input  logic                        WrEn_SI,
    input  logic [ADDR_WIDTH-1:0]       Addr_DI,
    input  logic [MEM_WIDTH-1:0]        PAR_In_DI,
    input  logic signed [IN_WIDTH-1:0]  NYQI_In_DI,
    input  logic                        NYQI_InValid_SI,
    output logic                        NYQI_Ready_SO,
    output logic signed [OUT_WIDTH-1:0] NYQI_Out_DO,
    output logic                        NYQI_OutValid_DO,
    output logic [2:0]                  NYQI_Phase_DO,
    output logic                        NYQI_Overrun_SO
);

    localparam int NUM_PHASES = 8;
    localparam int NUM_TAPS   = 4;
    localparam int NUM_COEF   = NUM_PHASES * NUM_TAPS;
    localparam int PROD_W     = MEM_WIDTH + IN_WIDTH;
    localparam int SUM_W      = PROD_W + 2;
    localparam int FRAC       = MEM_WIDTH - 1;

    localparam logic [ADDR_WIDTH-1:0] ADDR_EN  = ADDR_WIDTH'(32);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CLR = ADDR_WIDTH'(33);

    localparam logic signed [OUT_WIDTH-1:0] MAX_OUT =
        {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] MIN_OUT =
        {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'(MAX_OUT);
    localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(MIN_OUT);
    localparam logic signed [SUM_W-1:0] HALF    = SUM_W'(1) << (FRAC - 1);

    typedef enum logic {IDLE, RUN} state_t;

    logic signed [MEM_WIDTH-1:0] coef [NUM_COEF];
    logic                        enable;
    logic                        en_nxt;
    logic                        ready;
    logic                        accept;
    logic                        drop;
    logic                        overrun;

    state_t                      state;
    logic [2:0]                  phase;
    logic signed [IN_WIDTH-1:0]  x [NUM_TAPS];

    logic signed [PROD_W-1:0]    prod_c [NUM_TAPS];
    logic signed [PROD_W-1:0]    prod_q [NUM_TAPS];
    logic                        prod_vld;
    logic [2:0]                  prod_ph;

    logic signed [SUM_W-1:0]     sum;
    logic signed [SUM_W-1:0]     rnd;
    logic signed [SUM_W-1:0]     shr;
    logic signed [OUT_WIDTH-1:0] sat;

    assign ready  = enable &&
                    ((state == IDLE) || ((state == RUN) && (phase == 3'd7)));
    assign accept = NYQI_InValid_SI && ready;
    assign drop   = NYQI_InValid_SI && enable && !ready;

    // A disable write must clear the datapath on the same edge it lands
    assign en_nxt = (WrEn_SI && (Addr_DI == ADDR_EN)) ? PAR_In_DI[0] : enable;

    assign NYQI_Ready_SO   = ready;
    assign NYQI_Overrun_SO = overrun;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int i = 0; i < NUM_COEF; i++) coef[i] <= '0;
            enable  <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (WrEn_SI && (Addr_DI < ADDR_EN)) coef[Addr_DI[4:0]] <= PAR_In_DI;
            enable <= en_nxt;
            if (WrEn_SI && (Addr_DI == ADDR_CLR)) overrun <= 1'b0;
            if (drop) overrun <= 1'b1;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state <= IDLE;
            phase <= 3'd0;
            for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
        end else if (!en_nxt) begin
            state <= IDLE;
            phase <= 3'd0;
            for (int k = 0; k < NUM_TAPS; k++) x[k] <= '0;
        end else if (accept) begin
            x[0]  <= NYQI_In_DI;
            for (int k = 1; k < NUM_TAPS; k++) x[k] <= x[k-1];
            state <= RUN;
            phase <= 3'd0;
        end else if (state == RUN) begin
            if (phase == 3'd7) state <= IDLE;
            phase <= phase + 3'd1;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_TAPS; k++) begin
            prod_c[k] = coef[{k[1:0], phase}] * x[k];
        end
    end

    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_TAPS; k++) sum = sum + SUM_W'(prod_q[k]);
        rnd = sum + HALF;
        shr = rnd >>> FRAC;
        if (shr > SAT_MAX) begin
            sat = MAX_OUT;
        end else if (shr < SAT_MIN) begin
            sat = MIN_OUT;
        end else begin
            sat = shr[OUT_WIDTH-1:0];
        end
    end

    // Products registered first, then sum/round/saturate into the output
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int k = 0; k < NUM_TAPS; k++) prod_q[k] <= '0;
            prod_vld         <= 1'b0;
            prod_ph          <= 3'd0;
            NYQI_Out_DO      <= '0;
            NYQI_OutValid_DO <= 1'b0;
            NYQI_Phase_DO    <= 3'd0;
        end else begin
            prod_vld <= en_nxt && (state == RUN);
            prod_ph  <= phase;
            if (state == RUN) prod_q <= prod_c;
            NYQI_OutValid_DO <= en_nxt && prod_vld;
            if (en_nxt && prod_vld) begin
                NYQI_Out_DO   <= sat;
                NYQI_Phase_DO <= prod_ph;
            end
        end
    end

endmodule

// File: tb/tb_nyq_interp.sv
// Self-checking bench for nyq_interp: behavioural model feeds a
// scoreboard of expected outputs tagged with the cycle they must appear.
module tb_nyq_interp;

    logic               clk;
    logic               rst_n;
    logic               wr;
    logic [5:0]         addr;
    logic [23:0]        din;
    logic signed [23:0] xin;
    logic               inval;
    logic               rdy;
    logic signed [23:0] dout;
    logic               dvld;
    logic [2:0]         dph;
    logic               ovr;

    nyq_interp dut (
        .Clk_CI          (clk),
        .Rst_RBI         (rst_n),
        .WrEn_SI         (wr),
        .Addr_DI         (addr),
        .PAR_In_DI       (din),
        .NYQI_In_DI      (xin),
        .NYQI_InValid_SI (inval),
        .NYQI_Ready_SO   (rdy),
        .NYQI_Out_DO     (dout),
        .NYQI_OutValid_DO(dvld),
        .NYQI_Phase_DO   (dph),
        .NYQI_Overrun_SO (ovr)
    );

    typedef struct {
        logic [23:0] v;
        logic [2:0]  ph;
        int          cyc;
    } exp_t;

    exp_t               exp_q [$];
    exp_t               mon_e;
    int                 checks = 0;
    int                 failures = 0;
    int                 cyc = 0;
    logic [23:0]        last_out = '0;
    logic [2:0]         last_ph = '0;

    logic               m_en = 0;
    logic               m_run = 0;
    logic [2:0]         m_ph = 0;
    logic               m_ovr = 0;
    logic signed [23:0] m_x [4];
    logic signed [23:0] m_h [32];

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic logic mrdy();
        return m_en && (!m_run || (m_ph == 3'd7));
    endfunction

    function automatic logic [23:0] calc(input int p, input logic signed [23:0] s);
        longint acc;
        longint xs [4];
        xs[0] = longint'(s);
        xs[1] = longint'(m_x[0]);
        xs[2] = longint'(m_x[1]);
        xs[3] = longint'(m_x[2]);
        acc = 0;
        for (int k = 0; k < 4; k++) acc += longint'(m_h[8*k+p]) * xs[k];
        acc = (acc + 64'sd4194304) >>> 23;
        if (acc > 64'sd8388607) acc = 64'sd8388607;
        if (acc < -64'sd8388608) acc = -64'sd8388608;
        return acc[23:0];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_en  <= 1'b0;
            m_run <= 1'b0;
            m_ph  <= 3'd0;
            m_ovr <= 1'b0;
            for (int i = 0; i < 4; i++) m_x[i] <= '0;
            for (int i = 0; i < 32; i++) m_h[i] <= '0;
            exp_q.delete();
        end else begin
            cyc <= cyc + 1;
            if (wr && addr == 6'd33) m_ovr <= 1'b0;
            if (inval && m_en && !mrdy()) m_ovr <= 1'b1;
            if (wr && addr == 6'd32 && !din[0]) begin
                m_run <= 1'b0;
                m_ph  <= 3'd0;
                for (int i = 0; i < 4; i++) m_x[i] <= '0;
                exp_q.delete();
            end else if (inval && mrdy()) begin
                for (int p = 0; p < 8; p++)
                    exp_q.push_back('{calc(p, xin), 3'(p), cyc + p + 3});
                m_x[0] <= xin;
                for (int i = 1; i < 4; i++) m_x[i] <= m_x[i-1];
                m_run <= 1'b1;
                m_ph  <= 3'd0;
            end else if (m_run) begin
                if (m_ph == 3'd7) m_run <= 1'b0;
                m_ph <= m_ph + 3'd1;
            end
            if (wr && addr == 6'd32) m_en <= din[0];
            if (wr && addr < 6'd32) m_h[addr[4:0]] <= din;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (dvld) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_out got=%h phase=%0d cyc=%0d", dout, dph, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (dout !== mon_e.v || dph !== mon_e.ph || cyc !== mon_e.cyc) begin
                        failures++;
                        $display("FAIL sb_out got=%h/ph%0d/cyc%0d exp=%h/ph%0d/cyc%0d",
                                 dout, dph, cyc, mon_e.v, mon_e.ph, mon_e.cyc);
                    end
                end
                last_out = dout;
                last_ph  = dph;
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missing_out exp=%h ph%0d cyc%0d now=%0d",
                         exp_q[0].v, exp_q[0].ph, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_par(input int a, input logic [23:0] d);
        wr = 1'b1;
        addr = 6'(a);
        din = d;
        tick();
        wr = 1'b0;
    endtask

    task automatic clear_hist();
        wr_par(32, 24'd0);
        wr_par(32, 24'd1);
    endtask

    task automatic send(input logic [23:0] s);
        int n = 0;
        while (!mrdy() && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL send_ready got=%b exp=1 waited=%0d", rdy, n);
        end
        xin = s;
        inval = 1'b1;
        tick();
        inval = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 64) begin
            tick();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain_timeout left=%0d exp=0", exp_q.size());
            exp_q.delete();
        end
        tick();
        tick();
        checks++;
        if (dvld !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid got=%b exp=0", dvld);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 24'd0 || dvld !== 1'b0 || dph !== 3'd0 ||
            ovr !== 1'b0 || rdy !== 1'b0) begin
            failures++;
            $display("FAIL reset_state out=%h vld=%b ph=%0d ovr=%b rdy=%b exp=0",
                     dout, dvld, dph, ovr, rdy);
        end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_gain();
        xin = 24'h200000;
        inval = 1'b1;
        tick();
        inval = 1'b0;
        checks++;
        if (ovr !== 1'b0 || dvld !== 1'b0) begin
            failures++;
            $display("FAIL disabled_drop ovr=%b vld=%b exp=0/0", ovr, dvld);
        end
        for (int j = 0; j < 8; j++) wr_par(j, 24'h400000);
        wr_par(32, 24'd1);
        send(24'h200000);
        drain();
        checks++;
        if (last_out !== 24'h100000 || last_ph !== 3'd7) begin
            failures++;
            $display("FAIL gain_last got=%h/ph%0d exp=100000/ph7", last_out, last_ph);
        end
    endtask

    task automatic test_impulse();
        for (int j = 0; j < 32; j++) wr_par(j, 24'(j << 16));
        clear_hist();
        send(24'h7FFFFF);
        send(24'h000000);
        send(24'h000000);
        send(24'h000000);
        drain();
        checks++;
        if (last_out !== 24'h1F0000) begin
            failures++;
            $display("FAIL impulse_last got=%h exp=1f0000", last_out);
        end
    endtask

    task automatic test_saturation();
        for (int j = 0; j < 32; j++) wr_par(j, 24'h7FFFFF);
        clear_hist();
        for (int i = 0; i < 4; i++) send(24'h7FFFFF);
        drain();
        checks++;
        if (last_out !== 24'h7FFFFF) begin
            failures++;
            $display("FAIL sat_pos got=%h exp=7fffff", last_out);
        end
        for (int i = 0; i < 4; i++) send(24'h800000);
        drain();
        checks++;
        if (last_out !== 24'h800000) begin
            failures++;
            $display("FAIL sat_neg got=%h exp=800000", last_out);
        end
    endtask

    task automatic test_overrun();
        for (int j = 0; j < 32; j++) wr_par(j, (j < 16) ? 24'h400000 : 24'h0);
        clear_hist();
        send(24'h200000);
        tick();
        tick();
        tick();
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL ovr_ready got=%b exp=0", rdy);
        end
        xin = 24'h7FFFFF;
        inval = 1'b1;
        tick();
        inval = 1'b0;
        checks++;
        if (ovr !== 1'b1) begin
            failures++;
            $display("FAIL ovr_set got=%b exp=1", ovr);
        end
        drain();
        send(24'h000000);
        drain();
        checks++;
        if (last_out !== 24'h100000) begin
            failures++;
            $display("FAIL ovr_history got=%h exp=100000", last_out);
        end
        wr_par(33, 24'd0);
        checks++;
        if (ovr !== 1'b0) begin
            failures++;
            $display("FAIL ovr_clear got=%b exp=0", ovr);
        end
    endtask

    task automatic test_reset_mid();
        send(24'h200000);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (dout !== 24'd0 || dvld !== 1'b0 || dph !== 3'd0) begin
            failures++;
            $display("FAIL rst_mid out=%h vld=%b ph=%0d exp=0", dout, dvld, dph);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        checks++;
        if (rdy !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready got=%b exp=0", rdy);
        end
        wr_par(32, 24'd1);
        checks++;
        if (rdy !== 1'b1) begin
            failures++;
            $display("FAIL reenable_ready got=%b exp=1", rdy);
        end
    endtask

    task automatic test_disable();
        for (int j = 0; j < 16; j++) wr_par(j, 24'h400000);
        send(24'h7FFFFF);
        tick();
        tick();
        tick();
        wr_par(32, 24'd0);
        checks++;
        if (rdy !== 1'b0 || dvld !== 1'b0) begin
            failures++;
            $display("FAIL disable_now rdy=%b vld=%b exp=0/0", rdy, dvld);
        end
        tick();
        wr_par(32, 24'd1);
        send(24'h200000);
        drain();
        checks++;
        if (last_out !== 24'h100000) begin
            failures++;
            $display("FAIL disable_hist got=%h exp=100000", last_out);
        end
    endtask

    initial begin
        rst_n = 1'b1;
        wr    = 1'b0;
        addr  = '0;
        din   = '0;
        xin   = '0;
        inval = 1'b0;
        #2;
        test_reset();
        test_gain();
        test_impulse();
        test_saturation();
        test_overrun();
        test_reset_mid();
        test_disable();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
